// File: rtl/legv8_multicycle_core.sv
// LEGv8-subset 64-bit multicycle core: FETCH / EXECUTE / MEM FSM with fixed-latency
// external instruction and data memories, 32x64 register file and a single ALU.
module legv8_multicycle_core #(
  parameter int IMEM_LATENCY = 3,
  parameter int DMEM_LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction_from_testbench,
  output logic [63:0] pcoutput_to_testbench,
  output logic [63:0] mainalu_to_datamemreaddata,
  output logic [63:0] readdata2_to_datamemwritedata,
  output logic        memwrite,
  output logic        memread,
  input  logic [63:0] datamemreaddata_to_mux3
);

  localparam int MAX_LAT = (IMEM_LATENCY > DMEM_LATENCY) ? IMEM_LATENCY : DMEM_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 2);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] IMEM_LAT_C = CNT_W'(IMEM_LATENCY);
  localparam logic [CNT_W-1:0] DMEM_LAT_C = CNT_W'(DMEM_LATENCY);

  typedef enum logic [1:0] {S_FETCH, S_EXECUTE, S_MEM} state_t;
  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDI, OP_SUBI,
    OP_LDUR, OP_STUR, OP_CBZ, OP_B
  } op_t;

  function automatic op_t decode_op(input logic [10:0] opc);
    op_t op;
    op = OP_NOP;
    case (opc)
      11'h458: op = OP_ADD;
      11'h658: op = OP_SUB;
      11'h450: op = OP_AND;
      11'h550: op = OP_ORR;
      11'h7C2: op = OP_LDUR;
      11'h7C0: op = OP_STUR;
      default: begin
        if (opc[10:1] == 10'h244)     op = OP_ADDI;
        else if (opc[10:1] == 10'h344) op = OP_SUBI;
        else if (opc[10:3] == 8'hB4)   op = OP_CBZ;
        else if (opc[10:5] == 6'h05)   op = OP_B;
        else                           op = OP_NOP;
      end
    endcase
    return op;
  endfunction

  state_t           state_r, next_state_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic [63:0]      pc_r, pc_next_s, pc_plus4_s, br19_s, br26_s;
  logic [31:0]      ir_r;
  logic [63:0]      rf_r [0:31];
  logic [63:0]      alu_out_r, wdata_out_r;
  logic             memread_r, memwrite_r;

  op_t         fetch_op_s, ir_op_s;
  logic [4:0]  rn_s, rm_s;
  logic [63:0] rd1_s, rd2_s, alu_s;
  logic        fetch_done_s, mem_done_s, out_clear_s;
  logic        rf_we_s;
  logic [4:0]  rf_waddr_s;
  logic [63:0] rf_wdata_s;

  assign pcoutput_to_testbench         = pc_r;
  assign mainalu_to_datamemreaddata    = alu_out_r;
  assign readdata2_to_datamemwritedata = wdata_out_r;
  assign memread                       = memread_r;
  assign memwrite                      = memwrite_r;

  assign fetch_done_s = (state_r == S_FETCH) && (cnt_r == IMEM_LAT_C);
  assign mem_done_s   = (state_r == S_MEM) && (cnt_r == DMEM_LAT_C);
  assign ir_op_s      = decode_op(ir_r[31:21]);
  assign pc_plus4_s   = pc_r + 64'd4;
  assign br19_s       = {{43{ir_r[23]}}, ir_r[23:5], 2'b00};
  assign br26_s       = {{36{ir_r[25]}}, ir_r[25:0], 2'b00};

  // Operand read and ALU work on the incoming word so results are registered at the fetch edge.
  always_comb begin
    fetch_op_s = decode_op(instruction_from_testbench[31:21]);
    rn_s       = instruction_from_testbench[9:5];
    if (fetch_op_s inside {OP_LDUR, OP_STUR, OP_CBZ}) rm_s = instruction_from_testbench[4:0];
    else                                               rm_s = instruction_from_testbench[20:16];
    rd1_s = (rn_s == 5'd31) ? 64'd0 : rf_r[rn_s];
    rd2_s = (rm_s == 5'd31) ? 64'd0 : rf_r[rm_s];
    alu_s = 64'd0;
    case (fetch_op_s)
      OP_ADD:           alu_s = rd1_s + rd2_s;
      OP_SUB:           alu_s = rd1_s - rd2_s;
      OP_AND:           alu_s = rd1_s & rd2_s;
      OP_ORR:           alu_s = rd1_s | rd2_s;
      OP_ADDI:          alu_s = rd1_s + {52'd0, instruction_from_testbench[21:10]};
      OP_SUBI:          alu_s = rd1_s - {52'd0, instruction_from_testbench[21:10]};
      OP_LDUR, OP_STUR: alu_s = rd1_s + {{55{instruction_from_testbench[20]}}, instruction_from_testbench[20:12]};
      default:          alu_s = 64'd0;
    endcase
  end

  // Next-state, PC update and register write control.
  always_comb begin
    next_state_s = state_r;
    cnt_next_s   = cnt_r;
    pc_next_s    = pc_r;
    rf_we_s      = 1'b0;
    rf_waddr_s   = 5'd0;
    rf_wdata_s   = 64'd0;
    out_clear_s  = 1'b0;
    case (state_r)
      S_FETCH: begin
        if (fetch_done_s) begin
          next_state_s = S_EXECUTE;
          cnt_next_s   = CNT_ZERO;
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      S_EXECUTE: begin
        next_state_s = S_FETCH;
        out_clear_s  = 1'b1;
        pc_next_s    = pc_plus4_s;
        case (ir_op_s)
          OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDI, OP_SUBI: begin
            rf_we_s    = 1'b1;
            rf_waddr_s = ir_r[4:0];
            rf_wdata_s = alu_out_r;
          end
          OP_LDUR, OP_STUR: begin
            next_state_s = S_MEM;
            out_clear_s  = 1'b0;
            pc_next_s    = pc_r;
          end
          // wdata_out_r holds X[Rt] captured at the fetch edge.
          OP_CBZ: begin
            if (wdata_out_r == 64'd0) pc_next_s = pc_r + br19_s;
            else                      pc_next_s = pc_plus4_s;
          end
          OP_B:    pc_next_s = pc_r + br26_s;
          default: pc_next_s = pc_plus4_s;
        endcase
      end
      S_MEM: begin
        if (mem_done_s) begin
          rf_we_s      = (ir_op_s == OP_LDUR);
          rf_waddr_s   = ir_r[4:0];
          rf_wdata_s   = datamemreaddata_to_mux3;
          pc_next_s    = pc_plus4_s;
          cnt_next_s   = CNT_ZERO;
          next_state_s = S_FETCH;
          out_clear_s  = 1'b1;
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        next_state_s = S_FETCH;
        cnt_next_s   = CNT_ZERO;
      end
    endcase
  end

  // FSM state, latency counter, PC and instruction register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_FETCH;
      cnt_r   <= CNT_ZERO;
      pc_r    <= 64'd0;
      ir_r    <= 32'd0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= cnt_next_s;
      pc_r    <= pc_next_s;
      if (fetch_done_s) ir_r <= instruction_from_testbench;
    end
  end

  // Memory-side outputs are loaded at the fetch edge and held through EXECUTE and MEM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_out_r   <= 64'd0;
      wdata_out_r <= 64'd0;
      memread_r   <= 1'b0;
      memwrite_r  <= 1'b0;
    end else if (fetch_done_s) begin
      alu_out_r   <= alu_s;
      wdata_out_r <= rd2_s;
      memread_r   <= (fetch_op_s == OP_LDUR);
      memwrite_r  <= (fetch_op_s == OP_STUR);
    end else if (out_clear_s) begin
      alu_out_r   <= 64'd0;
      wdata_out_r <= 64'd0;
      memread_r   <= 1'b0;
      memwrite_r  <= 1'b0;
    end
  end

  // Register file; X31 is never written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf_r[i] <= 64'd0;
    end else if (rf_we_s && (rf_waddr_s != 5'd31)) begin
      rf_r[rf_waddr_s] <= rf_wdata_s;
    end
  end

endmodule

// File: tb/tb_legv8_multicycle_core.sv
// Self-checking bench for legv8_multicycle_core: directed vector table, reset-in-MEM
// sequence and randomized instruction stream checked against an ISA-level model.
module tb_legv8_multicycle_core;
  localparam int IL = 3;
  localparam int DL = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic [63:0] pc, addr, wdata, ld;
  logic        mw, mr;

  legv8_multicycle_core #(.IMEM_LATENCY(IL), .DMEM_LATENCY(DL)) u_dut (
    .clk(clk),
    .reset(reset),
    .instruction_from_testbench(instr),
    .pcoutput_to_testbench(pc),
    .mainalu_to_datamemreaddata(addr),
    .readdata2_to_datamemwritedata(wdata),
    .memwrite(mw),
    .memread(mr),
    .datamemreaddata_to_mux3(ld)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Architectural model state
  logic [63:0] mx [32];
  logic [63:0] mpc;

  typedef struct {
    logic [31:0] w;
    logic [63:0] ldv;
    logic        emr;
    logic        emw;
    logic [63:0] eaddr;
    logic [63:0] ewd;
    logic [63:0] epc;
  } vec_t;

  vec_t vt [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  function automatic logic [63:0] rx(input logic [4:0] r);
    return (r == 5'd31) ? 64'd0 : mx[r];
  endfunction

  task automatic wr(input logic [4:0] r, input logic [63:0] v);
    if (r != 5'd31) mx[r] = v;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mx[i] = 64'd0;
    mpc = 64'd0;
  endtask

  // Instruction-level semantics: register effects, memory-port expectations, next PC.
  task automatic model_exec(input logic [31:0] w, input logic [63:0] ldv,
                            output logic emr, output logic emw,
                            output logic [63:0] eaddr, output logic [63:0] ewd,
                            output logic [63:0] npc);
    logic [4:0] rd, rn, rm;
    longint off;
    rd = w[4:0]; rn = w[9:5]; rm = w[20:16];
    emr = 1'b0; emw = 1'b0; eaddr = 64'd0; ewd = 64'd0;
    npc = mpc + 64'd4;
    if (w[31:21] == 11'h458)      wr(rd, rx(rn) + rx(rm));
    else if (w[31:21] == 11'h658) wr(rd, rx(rn) - rx(rm));
    else if (w[31:21] == 11'h450) wr(rd, rx(rn) & rx(rm));
    else if (w[31:21] == 11'h550) wr(rd, rx(rn) | rx(rm));
    else if (w[31:21] == 11'h7C2 || w[31:21] == 11'h7C0) begin
      off   = $signed(w[20:12]);
      eaddr = rx(rn) + 64'(off);
      ewd   = rx(rd);
      if (w[31:21] == 11'h7C2) begin
        emr = 1'b1;
        wr(rd, ldv);
      end else begin
        emw = 1'b1;
      end
    end
    else if (w[31:22] == 10'h244) wr(rd, rx(rn) + 64'(w[21:10]));
    else if (w[31:22] == 10'h344) wr(rd, rx(rn) - 64'(w[21:10]));
    else if (w[31:24] == 8'hB4) begin
      if (rx(rd) == 64'd0) begin
        off = $signed(w[23:5]);
        npc = mpc + 64'(off * 4);
      end
    end
    else if (w[31:26] == 6'h05) begin
      off = $signed(w[25:0]);
      npc = mpc + 64'(off * 4);
    end
    mpc = npc;
  endtask

  // Called at the first FETCH cycle (just after a falling edge); returns at the next one.
  task automatic run_instr(input logic [31:0] w, input logic [63:0] ldv,
                           input logic emr, input logic emw,
                           input logic [63:0] eaddr, input logic [63:0] ewd,
                           input logic [63:0] pc_before, input logic [63:0] pc_after);
    int n;
    instr = w;
    ld    = ldv;
    n = (emr || emw) ? (IL + DL + 3) : (IL + 2);
    for (int c = 0; c < n; c++) begin
      #1;
      check($sformatf("pc %h c%0d", w, c), pc, pc_before);
      if (c <= IL) begin
        check($sformatf("fetch_addr %h c%0d", w, c), addr, 64'd0);
        check($sformatf("fetch_wdata %h c%0d", w, c), wdata, 64'd0);
        check($sformatf("fetch_rdwr %h c%0d", w, c), {62'd0, mr, mw}, 64'd0);
      end else begin
        check($sformatf("rdwr %h c%0d", w, c), {62'd0, mr, mw}, {62'd0, emr, emw});
        if (emr || emw) begin
          check($sformatf("addr %h c%0d", w, c), addr, eaddr);
          check($sformatf("wdata %h c%0d", w, c), wdata, ewd);
        end
      end
      @(negedge clk);
    end
    #1;
    check($sformatf("next_pc %h", w), pc, pc_after);
    check($sformatf("post_rdwr %h", w), {62'd0, mr, mw}, 64'd0);
    check($sformatf("post_addr %h", w), addr, 64'd0);
  endtask

  task automatic exec_model(input logic [31:0] w, input logic [63:0] ldv);
    logic emr, emw;
    logic [63:0] ea, ewd, npc, pcb;
    pcb = mpc;
    model_exec(w, ldv, emr, emw, ea, ewd, npc);
    run_instr(w, ldv, emr, emw, ea, ewd, pcb, npc);
  endtask

  function automatic logic [4:0] rand_reg();
    int r;
    r = int'($urandom_range(0, 8));
    return (r == 8) ? 5'd31 : 5'(r);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [18:0] i19;
    logic [25:0] i26;
    logic [11:0] i12;
    logic [8:0]  i9;
    int v;
    i12 = 12'($urandom);
    i9  = 9'($urandom);
    v   = int'($urandom_range(0, 16)) - 8;
    i19 = v[18:0];
    i26 = {{7{i19[18]}}, i19};
    case ($urandom_range(0, 10))
      0:  w = {11'h458, rand_reg(), 6'd0, rand_reg(), rand_reg()};
      1:  w = {11'h658, rand_reg(), 6'd0, rand_reg(), rand_reg()};
      2:  w = {11'h450, rand_reg(), 6'd0, rand_reg(), rand_reg()};
      3:  w = {11'h550, rand_reg(), 6'd0, rand_reg(), rand_reg()};
      4:  w = {10'h244, i12, rand_reg(), rand_reg()};
      5:  w = {10'h344, i12, rand_reg(), rand_reg()};
      6:  w = {11'h7C2, i9, 2'b00, rand_reg(), rand_reg()};
      7:  w = {11'h7C0, i9, 2'b00, rand_reg(), rand_reg()};
      8:  w = {8'hB4, i19, rand_reg()};
      9:  w = {6'h05, i26};
      default: w = $urandom;
    endcase
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic emr_d, emw_d;
    logic [63:0] ea_d, ewd_d, npc_d;

    vt[0] = '{32'h910017E1, 64'd0,      1'b0, 1'b0, 64'd0, 64'd0,       64'h04};
    vt[1] = '{32'h8B010022, 64'd0,      1'b0, 1'b0, 64'd0, 64'd0,       64'h08};
    vt[2] = '{32'hF80083E2, 64'd0,      1'b0, 1'b1, 64'd8, 64'd10,      64'h0C};
    vt[3] = '{32'hF84083E3, 64'hDEAD,   1'b1, 1'b0, 64'd8, 64'd0,       64'h10};
    vt[4] = '{32'hB400007F, 64'd0,      1'b0, 1'b0, 64'd0, 64'd0,       64'h1C};
    vt[5] = '{32'h17FFFFFE, 64'd0,      1'b0, 1'b0, 64'd0, 64'd0,       64'h14};
    vt[6] = '{32'hF80083E3, 64'd0,      1'b0, 1'b1, 64'd8, 64'hDEAD,    64'h18};
    vt[7] = '{32'hB4000061, 64'd0,      1'b0, 1'b0, 64'd0, 64'd0,       64'h1C};
    vt[8] = '{32'hCB020024, 64'd0,      1'b0, 1'b0, 64'd0, 64'd0,       64'h20};
    vt[9] = '{32'hF81FF024, 64'd0,      1'b0, 1'b1, 64'd4, 64'hFFFF_FFFF_FFFF_FFFB, 64'h24};

    reset = 1'b0;
    instr = 32'd0;
    ld    = 64'd0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset pc", pc, 64'd0);
    check("reset addr", addr, 64'd0);
    check("reset wdata", wdata, 64'd0);
    check("reset rdwr", {62'd0, mr, mw}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      model_exec(vt[i].w, vt[i].ldv, emr_d, emw_d, ea_d, ewd_d, npc_d);
      run_instr(vt[i].w, vt[i].ldv, vt[i].emr, vt[i].emw, vt[i].eaddr, vt[i].ewd,
                (i == 0) ? 64'd0 : vt[i-1].epc, vt[i].epc);
    end

    // Reset asserted in the middle of a load's MEM phase
    exec_model(32'h910027E5, 64'd0);
    instr = 32'hF84083E5;
    ld    = 64'h1234;
    for (int c = 0; c < IL + 3; c++) @(negedge clk);
    #1;
    check("mid_mem memread", {63'd0, mr}, 64'd1);
    reset = 1'b0;
    #1;
    check("abort pc", pc, 64'd0);
    check("abort addr", addr, 64'd0);
    check("abort wdata", wdata, 64'd0);
    check("abort rdwr", {62'd0, mr, mw}, 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    exec_model(32'hF80003E5, 64'd0);
    exec_model(32'h91001FFF, 64'd0);
    exec_model(32'hF80083FF, 64'd0);

    // Randomized stream against the model
    for (int i = 0; i < 80; i++) begin
      exec_model(rand_instr(), {$urandom, $urandom});
    end
    for (int r = 0; r < 32; r++) begin
      exec_model({11'h7C0, 9'd0, 2'b00, 5'd31, 5'(r)}, 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
